fb_wr_sched: RTL

- Write-port scheduler for the dual-half framebuffer memory that feeds the LED panel.
- Shares the single memory write port (11-bit address, wr0/wr1 bank strobes, 12-bit RGB data) between two requesters:
  - port A: the paint/cursor controller.
  - port B: a host/UART command writer.
- Contains a built-in full-screen clear engine that sweeps every address in both halves with a fixed colour.
- Sits between the requesters and the memory write inputs; the panel read path is untouched.

---
 rtl/fb_wr_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fb_wr_sched.sv
// Framebuffer write-port scheduler: round-robin arbitration of two requesters
// onto the single memory write port, plus a full-screen clear engine.
module fb_wr_sched #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W:0]   a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W:0]   b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr0,
    output logic              mem_wr1,
    output logic [DATA_W-1:0] mem_wdata
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   color_q, color_d;
    logic                ptr_q, ptr_d;     // 1: B was granted last, so A wins a tie
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wr0_q, mem_wr0_d;
    logic                mem_wr1_q, mem_wr1_d;
    logic                clr_busy_q, clr_busy_d;
    logic                clr_done_q, clr_done_d;
    logic                arb_ok;

    // Grants are combinational; gating on rst_n keeps them low during reset.
    assign arb_ok = rst_n && (state_q == IDLE) && !clr_start;
    assign a_gnt  = arb_ok && a_req && (!b_req || ptr_q);
    assign b_gnt  = arb_ok && b_req && (!a_req || !ptr_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        color_d     = color_q;
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr0_d   = 1'b0;
        mem_wr1_d   = 1'b0;
        clr_busy_d  = clr_busy_q;
        clr_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    // The first clear write is issued on acceptance so it shows next cycle.
                    state_d     = CLEAR;
                    color_d     = clr_color;
                    cnt_d       = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = clr_color;
                    mem_wr0_d   = 1'b1;
                    mem_wr1_d   = 1'b1;
                    clr_busy_d  = 1'b1;
                end else if (a_gnt) begin
                    mem_addr_d  = a_addr[ADDR_W-1:0];
                    mem_wdata_d = a_data;
                    mem_wr0_d   = !a_addr[ADDR_W];
                    mem_wr1_d   = a_addr[ADDR_W];
                    ptr_d       = 1'b0;
                end else if (b_gnt) begin
                    mem_addr_d  = b_addr[ADDR_W-1:0];
                    mem_wdata_d = b_data;
                    mem_wr0_d   = !b_addr[ADDR_W];
                    mem_wr1_d   = b_addr[ADDR_W];
                    ptr_d       = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == '1) begin
                    state_d    = DONE;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + ADDR_W'(1);
                    mem_addr_d  = cnt_q + ADDR_W'(1);
                    mem_wdata_d = color_q;
                    mem_wr0_d   = 1'b1;
                    mem_wr1_d   = 1'b1;
                end
            end
            DONE: begin
                state_d    = IDLE;
                clr_busy_d = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                clr_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            color_q     <= '0;
            ptr_q       <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr0_q   <= 1'b0;
            mem_wr1_q   <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            ptr_q       <= ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr0_q   <= mem_wr0_d;
            mem_wr1_q   <= mem_wr1_d;
            clr_busy_q  <= clr_busy_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr0   = mem_wr0_q;
    assign mem_wr1   = mem_wr1_q;
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;

endmodule
